// File: rtl/idli_sqi_ctrl_m_pkg.sv
// Shared definitions for the SQI SRAM sequencer.
//   sqi_state_t   : sequencer phases
//   sqi_data_t    : one SIO nibble, used by every nibble-wide port
//   SQI_CMD_READ  : serial SRAM READ opcode
//   SQI_CMD_WRITE : serial SRAM WRITE opcode
package idli_sqi_ctrl_m_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        END
    } sqi_state_t;

    typedef logic [3:0] sqi_data_t;

    localparam logic [7:0] SQI_CMD_READ  = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

    // Phase lengths in SCK cycles (one nibble per cycle).
    localparam int unsigned SQI_CMD_CYC  = 2;
    localparam int unsigned SQI_ADDR_CYC = 6;

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// SQI SRAM sequencer: issues command, 24b address and dummy phases on the
// 4-bit SIO bus, then streams nibbles until redirected or terminated.
//
// Optional feature macro: IDLI_SQI_WRITE_EN (write transactions). When it is
// undefined every transaction is a read and o_sqi_wr_ack is tied low.
//
// Ports:
//   i_sqi_gck       clock (SCK derived from it, gated by o_sqi_sck_en)
//   i_sqi_rst       synchronous active-high reset
//   i_sqi_req       request new transaction (start or redirect)
//   i_sqi_wr        transaction is a write (IDLI_SQI_WRITE_EN only)
//   i_sqi_addr      16b word address; byte address = {7'b0, addr, 1'b0}
//   o_sqi_acp       request accepted this cycle
//   i_sqi_end       terminate the current transaction
//   i_sqi_stall     consumer not ready; freezes DATA
//   o_sqi_rd_data   read nibble
//   o_sqi_rd_vld    o_sqi_rd_data valid
//   i_sqi_wr_data   write nibble
//   o_sqi_wr_ack    i_sqi_wr_data consumed this cycle
//   o_sqi_cs_n      SRAM chip select, active-low
//   o_sqi_sck_en    SCK enable for this cycle
//   o_sqi_sio_out   SIO drive value
//   o_sqi_sio_oe    SIO output enable
//   i_sqi_sio_in    SIO sampled value
module idli_sqi_ctrl_m
    import idli_sqi_ctrl_m_pkg::*;
#(
    parameter int unsigned SQI_DUMMY_CYC = 2
) (
    input  logic        i_sqi_gck,
    input  logic        i_sqi_rst,
    input  logic        i_sqi_req,
    input  logic        i_sqi_wr,
    input  logic [15:0] i_sqi_addr,
    output logic        o_sqi_acp,
    input  logic        i_sqi_end,
    input  logic        i_sqi_stall,
    output sqi_data_t   o_sqi_rd_data,
    output logic        o_sqi_rd_vld,
    input  sqi_data_t   i_sqi_wr_data,
    output logic        o_sqi_wr_ack,
    output logic        o_sqi_cs_n,
    output logic        o_sqi_sck_en,
    output sqi_data_t   o_sqi_sio_out,
    output logic        o_sqi_sio_oe,
    input  sqi_data_t   i_sqi_sio_in
);

    sqi_state_t  state;
    sqi_state_t  state_nx;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nx;
    logic [31:0] sr;        // {cmd, byte address}, MS nibble on SIO
    logic        wr_q;      // current transaction is a write
    logic        pend;      // redirect accepted in DATA, CMD follows END
    logic        wr_in;
    logic        data_wr;   // write data being driven this cycle

`ifdef IDLI_SQI_WRITE_EN
    assign wr_in = i_sqi_wr;
`else
    logic unused_wr;
    assign wr_in     = 1'b0;
    assign unused_wr = ^{i_sqi_wr, i_sqi_wr_data};
`endif

    // Counter value loaded on entry to each phase; the phase ends at zero.
    function automatic logic [2:0] phase_len(input sqi_state_t s);
        case (s)
            CMD:     phase_len = 3'(SQI_CMD_CYC - 1);
            ADDR:    phase_len = 3'(SQI_ADDR_CYC - 1);
            DUMMY:   phase_len = 3'(SQI_DUMMY_CYC - 1);
            default: phase_len = '0;
        endcase
    endfunction

    assign o_sqi_acp = i_sqi_req && !i_sqi_rst && (state == IDLE || state == DATA);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (o_sqi_acp) state_nx = CMD;
            CMD:     if (cnt == '0) state_nx = ADDR;
            ADDR:    if (cnt == '0) state_nx = wr_q ? DATA : DUMMY;
            DUMMY:   if (cnt == '0) state_nx = DATA;
            DATA:    if (o_sqi_acp || i_sqi_end) state_nx = END;
            END:     state_nx = pend ? CMD : IDLE;
            default: state_nx = IDLE;
        endcase

        if (state_nx != state) begin
            cnt_nx = phase_len(state_nx);
        end else if (cnt != '0) begin
            cnt_nx = cnt - 3'd1;
        end else begin
            cnt_nx = '0;
        end
    end

    always_comb begin
        data_wr       = (state == DATA) && wr_q;
        o_sqi_cs_n    = !(state == CMD || state == ADDR || state == DUMMY || state == DATA);
        o_sqi_sio_oe  = (state == CMD) || (state == ADDR) || data_wr;
        o_sqi_sck_en  = (state == CMD) || (state == ADDR) || (state == DUMMY) ||
                        ((state == DATA) && !i_sqi_stall);
        o_sqi_sio_out = '0;
        if (state == CMD || state == ADDR) begin
            o_sqi_sio_out = sr[31:28];
        end else if (data_wr) begin
            o_sqi_sio_out = i_sqi_wr_data;
        end
`ifdef IDLI_SQI_WRITE_EN
        o_sqi_wr_ack  = data_wr && !i_sqi_stall;
`else
        o_sqi_wr_ack  = 1'b0;
`endif
    end

    always_ff @(posedge i_sqi_gck) begin
        if (i_sqi_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            sr            <= '0;
            wr_q          <= 1'b0;
            pend          <= 1'b0;
            o_sqi_rd_data <= '0;
            o_sqi_rd_vld  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;

            // A redirect loads the new command/address during DATA; it is
            // only shifted out once CMD is reached after END.
            if (o_sqi_acp) begin
                sr   <= {(wr_in ? SQI_CMD_WRITE : SQI_CMD_READ), 7'b0, i_sqi_addr, 1'b0};
                wr_q <= wr_in;
            end else if (state == CMD || state == ADDR) begin
                sr <= {sr[27:0], 4'b0};
            end

            if (state == DATA && o_sqi_acp) begin
                pend <= 1'b1;
            end else if (state == END) begin
                pend <= 1'b0;
            end

            if (state == DATA && !wr_q && o_sqi_sck_en) begin
                o_sqi_rd_data <= i_sqi_sio_in;
            end
            // The nibble sampled while leaving DATA is discarded.
            o_sqi_rd_vld <= (state == DATA) && !wr_q && o_sqi_sck_en &&
                            !o_sqi_acp && !i_sqi_end;
        end
    end

endmodule
